// File: rtl/datapath_unit_if.sv
// Control, data and status bundle between the sequencing controller and datapath_unit.
// The master side drives instruction/control; the slave side returns C and the flags.
interface datapath_unit_if;
    logic [15:0] instr;
    logic [1:0]  reg_sel;
    logic [1:0]  wb_sel;
    logic        w_en;
    logic        en_A;
    logic        en_B;
    logic        en_C;
    logic        en_status;
    logic        sel_A;
    logic        sel_B;
    logic [7:0]  pc;
    logic [15:0] mdata;
    logic [15:0] datapath_out;
    logic        Z_out;
    logic        N_out;
    logic        V_out;

    modport master (
        output instr, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, pc, mdata,
        input  datapath_out, Z_out, N_out, V_out
    );

    modport slave (
        input  instr, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, pc, mdata,
        output datapath_out, Z_out, N_out, V_out
    );
endinterface

// File: rtl/datapath_unit.sv
// 16-bit datapath: 8-entry register file, A/B operand latches, shifter, ALU,
// result register C and Z/N/V status flags. Synchronous active-low reset.
module datapath_unit (
    input  logic           clk,
    input  logic           rst_n,
    datapath_unit_if.slave dp
);
    logic [15:0] rf_q [8];
    logic [15:0] a_q, b_q, c_q;
    logic [2:0]  status_q;      // {Z, N, V}

    logic [2:0]  idx;
    logic        idx_vld;
    logic [15:0] rd_data;
    logic [15:0] wb_data;
    logic [15:0] sximm8, sximm5;
    logic [15:0] b_sh;
    logic [15:0] ain, bin;
    logic [15:0] c_d;
    logic [2:0]  status_d;
    logic        ovf;

    logic unused_instr_hi;
    assign unused_instr_hi = &{1'b0, dp.instr[15:13]};

    always_comb begin
        idx     = '0;
        idx_vld = 1'b1;
        case (dp.reg_sel)
            2'b10:   idx = dp.instr[10:8];
            2'b01:   idx = dp.instr[2:0];
            2'b00:   idx = dp.instr[7:5];
            default: idx_vld = 1'b0;
        endcase
    end

    assign rd_data = idx_vld ? rf_q[idx] : '0;
    assign sximm8  = {{8{dp.instr[7]}}, dp.instr[7:0]};
    assign sximm5  = {{11{dp.instr[4]}}, dp.instr[4:0]};

    always_comb begin
        wb_data = c_q;
        case (dp.wb_sel)
            2'b00:   wb_data = c_q;
            2'b01:   wb_data = {8'b0, dp.pc};
            2'b10:   wb_data = sximm8;
            default: wb_data = dp.mdata;
        endcase
    end

    always_comb begin
        b_sh = b_q;
        case (dp.instr[4:3])
            2'b00:   b_sh = b_q;
            2'b01:   b_sh = {b_q[14:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[15:1]};
            default: b_sh = {b_q[15], b_q[15:1]};
        endcase
    end

    assign ain = dp.sel_A ? '0 : a_q;
    assign bin = dp.sel_B ? sximm5 : b_sh;

    // Subtraction overflows when operand signs differ, i.e. when ~Bin shares Ain's sign.
    always_comb begin
        c_d = '0;
        ovf = 1'b0;
        case (dp.instr[12:11])
            2'b00: begin
                c_d = ain + bin;
                ovf = (ain[15] == bin[15]) && (c_d[15] != ain[15]);
            end
            2'b01: begin
                c_d = ain - bin;
                ovf = (ain[15] != bin[15]) && (c_d[15] != ain[15]);
            end
            2'b10:   c_d = ain & bin;
            default: c_d = ~bin;
        endcase
        status_d = {(c_d == '0), c_d[15], ovf};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            if (dp.w_en && idx_vld) rf_q[idx] <= wb_data;
            if (dp.en_A)      a_q      <= rd_data;
            if (dp.en_B)      b_q      <= rd_data;
            if (dp.en_C)      c_q      <= c_d;
            if (dp.en_status) status_q <= status_d;
        end
    end

    assign dp.datapath_out = c_q;
    assign dp.Z_out        = status_q[2];
    assign dp.N_out        = status_q[1];
    assign dp.V_out        = status_q[0];
endmodule

// File: tb/tb_datapath_unit.sv
// Directed scoreboard bench for datapath_unit: stimulus pushes expected {C,Z,N,V},
// an independent negedge monitor pops and compares against the DUT outputs.
module tb_datapath_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    datapath_unit_if bus ();

    datapath_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (bus.slave)
    );

    logic [18:0] exp_q [$];
    string       name_q [$];
    int          checks   = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [18:0] e;
            logic [18:0] act;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {bus.datapath_out, bus.Z_out, bus.N_out, bus.V_out};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got C=%h ZNV=%b%b%b, want C=%h ZNV=%b%b%b",
                         nm, act[18:3], act[2], act[1], act[0],
                         e[18:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] c,
                              input logic z, input logic n, input logic v);
        exp_q.push_back({c, z, n, v});
        name_q.push_back(nm);
    endtask

    task automatic idle();
        bus.instr     = '0;
        bus.reg_sel   = 2'b11;
        bus.wb_sel    = 2'b00;
        bus.w_en      = 1'b0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        bus.sel_B     = 1'b0;
    endtask

    task automatic wr_imm(input logic [2:0] r, input logic [7:0] imm);
        idle();
        bus.instr   = {5'b0, r, imm};
        bus.reg_sel = 2'b10;
        bus.wb_sel  = 2'b10;
        bus.w_en    = 1'b1;
        tick();
    endtask

    task automatic wr_src(input logic [2:0] r, input logic [1:0] ws);
        idle();
        bus.instr   = {5'b0, r, 8'h00};
        bus.reg_sel = 2'b10;
        bus.wb_sel  = ws;
        bus.w_en    = 1'b1;
        tick();
    endtask

    task automatic ld(input logic [2:0] r, input bit to_a);
        idle();
        bus.instr   = {5'b0, r, 8'h00};
        bus.reg_sel = 2'b10;
        bus.en_A    = to_a;
        bus.en_B    = !to_a;
        tick();
    endtask

    task automatic alu(input logic [1:0] op, input logic [1:0] sh, input bit sa,
                       input bit sb, input bit ec, input bit es, input logic [4:0] imm5);
        idle();
        bus.instr     = {3'b0, op, 6'b0, (sb ? imm5 : {sh, 3'b000})};
        bus.sel_A     = sa;
        bus.sel_B     = sb;
        bus.en_C      = ec;
        bus.en_status = es;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pc    = 8'h00;
        bus.mdata = 16'h0000;
        idle();
        rst_n = 1'b0;
        bus.en_C = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        wr_imm(3'd3, 8'hF0);
        ld(3'd3, 1'b0);
        alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("imm_write", 16'hFFF0, 1'b0, 1'b1, 1'b0);

        wr_imm(3'd1, 8'h07);
        wr_imm(3'd2, 8'h02);
        ld(3'd1, 1'b1);
        ld(3'd2, 1'b0);
        alu(2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("add", 16'h000B, 1'b0, 1'b0, 1'b0);

        wr_imm(3'd5, 8'h05);
        ld(3'd5, 1'b1);
        ld(3'd5, 1'b0);
        alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        expect_out("compare", 16'h000B, 1'b1, 1'b0, 1'b0);

        wr_imm(3'd7, 8'hFF);
        ld(3'd7, 1'b0);
        alu(2'b00, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("lsr_7fff", 16'h7FFF, 1'b0, 1'b0, 1'b0);
        wr_src(3'd6, 2'b00);
        wr_imm(3'd7, 8'h01);
        ld(3'd6, 1'b1);
        ld(3'd7, 1'b0);
        alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);

        bus.mdata = 16'h8004;
        wr_src(3'd0, 2'b11);
        ld(3'd0, 1'b0);
        alu(2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("asr_move", 16'hC002, 1'b0, 1'b1, 1'b0);
        alu(2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("not_move", 16'h3FFD, 1'b0, 1'b0, 1'b0);

        bus.pc = 8'hA5;
        wr_src(3'd2, 2'b01);
        ld(3'd2, 1'b0);
        alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("pc_wb", 16'h00A5, 1'b0, 1'b0, 1'b0);

        alu(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 5'b10011);
        expect_out("sximm5", 16'hFFF3, 1'b0, 1'b1, 1'b0);

        ld(3'd6, 1'b1);
        ld(3'd3, 1'b0);
        alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("sub_ovf", 16'h800F, 1'b0, 1'b1, 1'b1);

        ld(3'd1, 1'b1);
        ld(3'd5, 1'b0);
        alu(2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("and", 16'h0005, 1'b0, 1'b0, 1'b0);

        idle();
        bus.instr   = {5'b0, 3'd1, 8'h00};
        bus.reg_sel = 2'b11;
        bus.wb_sel  = 2'b10;
        bus.w_en    = 1'b1;
        tick();
        ld(3'd1, 1'b0);
        alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("noreg_write", 16'h0007, 1'b0, 1'b0, 1'b0);

        idle();
        bus.reg_sel = 2'b11;
        bus.en_B    = 1'b1;
        tick();
        alu(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("none_read", 16'hFFFF, 1'b0, 1'b1, 1'b0);

        wr_imm(3'd4, 8'h01);
        idle();
        bus.instr   = {5'b0, 3'd4, 8'h09};
        bus.reg_sel = 2'b10;
        bus.wb_sel  = 2'b10;
        bus.w_en    = 1'b1;
        bus.en_A    = 1'b1;
        tick();
        ld(3'd4, 1'b0);
        alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("rbw", 16'h000A, 1'b0, 1'b0, 1'b0);
        alu(2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("pre_reset", 16'hFFF6, 1'b0, 1'b1, 1'b0);

        idle();
        rst_n         = 1'b0;
        bus.instr     = {5'b0, 3'd4, 8'h00};
        bus.reg_sel   = 2'b10;
        bus.en_A      = 1'b1;
        bus.en_B      = 1'b1;
        bus.en_C      = 1'b1;
        bus.en_status = 1'b1;
        tick();
        rst_n = 1'b1;
        idle();
        expect_out("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0);

        alu(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("post_reset_b", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("post_reset_ab", 16'h0000, 1'b1, 1'b0, 1'b0);
        ld(3'd4, 1'b1);
        ld(3'd0, 1'b0);
        alu(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        expect_out("post_reset_rf", 16'h0000, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 The block SHALL have a clock `clk`: input, 1 bit, rising-edge clock for all state.
REQ-002 The block SHALL have a reset `rst_n`: input, 1 bit; reset rst_n, synchronous, active-low; clock clk.
REQ-003 The block SHALL have `instr`: input, 16 bits, current instruction word. Fields:
- rn = [10:8]
- rd = [7:5]
- shift = [4:3]
- rm = [2:0]
- alu_op = [12:11]
- imm8 = [7:0]
- imm5 = [4:0]
REQ-004 The block SHALL have `reg_sel`: input, 2 bits, register index source. 10 = rn, 01 = rm, 00 = rd, 11 = none.
REQ-005 The block SHALL have `wb_sel`: input, 2 bits, write-back source. 00 = C, 01 = {8'b0, pc}, 10 = sximm8, 11 = mdata.
REQ-006 The block SHALL have `w_en`: input, 1 bit, register-file write enable.
REQ-007 The block SHALL have `en_A`, `en_B`, `en_C`, `en_status`: inputs, 1 bit each, load enables for A, B, C and the status flags.
REQ-008 The block SHALL have `sel_A`: input, 1 bit. 1 = ALU operand A is 16'h0000; 0 = ALU operand A is register A.
REQ-009 The block SHALL have `sel_B`: input, 1 bit. 1 = ALU operand B is sximm5; 0 = ALU operand B is shifted register B.
REQ-010 The block SHALL have `pc`: input, 8 bits, program counter value for write-back.
REQ-011 The block SHALL have `mdata`: input, 16 bits, memory read data for write-back.
REQ-012 The block SHALL have `datapath_out`: output, 16 bits, equal to the contents of register C.
REQ-013 The block SHALL have `Z_out`, `N_out`, `V_out`: outputs, 1 bit each, registered zero, negative and overflow flags.

Function
REQ-014 The block SHALL contain a register file of eight 16-bit registers R0..R7, plus 16-bit registers A, B and C and a 3-bit status register.
REQ-015 The register index SHALL be decoded combinationally from `reg_sel` and `instr`.
REQ-016 The register-file read SHALL be combinational: read data = R[index]; with reg_sel = 11, read data = 16'h0000.
REQ-017 On a clk edge with w_en = 1 and reg_sel != 11, R[index] SHALL be loaded with the selected write-back value.
REQ-018 With w_en = 1 and reg_sel = 11, no register SHALL change.
REQ-019 sximm8 SHALL be the sign extension of imm8 to 16 bits; sximm5 SHALL be the sign extension of imm5 to 16 bits.
REQ-020 On a clk edge with en_A = 1, A SHALL load the register-file read data; with en_B = 1, B SHALL load it; A and B hold otherwise.
REQ-021 When a register is written and read into A or B in the same cycle, A or B SHALL capture the pre-write value (read-before-write).
REQ-022 The shifter SHALL operate on B as follows:
- shift 00: B unchanged
- shift 01: B << 1, zero fill
- shift 10: B >> 1, zero fill
- shift 11: B >> 1 with bit 15 preserved (arithmetic)
REQ-023 The ALU SHALL compute, with results truncated to 16 bits:
- alu_op 00: Ain + Bin
- alu_op 01: Ain - Bin
- alu_op 10: Ain & Bin
- alu_op 11: ~Bin
REQ-024 On a clk edge with en_C = 1, C SHALL load the ALU result.
REQ-025 On a clk edge with en_status = 1, the flags SHALL load from the ALU result:
- Z = (result == 0)
- N = result[15]
- V = signed overflow for add/sub (operand signs equal and result sign differs; for sub, Bin is compared inverted); V = 0 for alu_op 10/11
REQ-026 en_C and en_status SHALL be independent; both may be asserted in one cycle and both registers update.
REQ-027 The block SHALL have a latency of one cycle per stage: register-file → A/B (1 edge), A/B → C/status (1 edge), C → register-file write (1 edge); there are no combinational paths from control inputs to outputs.
REQ-028 All enables SHALL be allowed to assert simultaneously, and each affected register SHALL update per its own rule on the same edge.
REQ-029 Inputs SHALL be sampled only at rising clk edges, and outputs SHALL change only after edges.

Reset
REQ-030 At a clk edge with rst_n = 0, the block SHALL clear R0..R7, A, B, C, Z, N and V to 0, so that datapath_out = 16'h0000 and all flags read 0 after that edge.
REQ-031 Reset SHALL take priority over all enables; a reset asserted mid-operation SHALL discard any in-flight A/B/C contents.

Verification
REQ-032 Bench scenario, immediate write: reset, then w_en = 1, reg_sel = 10, wb_sel = 10, instr[10:8] = 3, imm8 = 8'hF0 -> R3 = 16'hFFF0.
REQ-033 Bench scenario, add: R1 = 7, R2 = 2; load A ← R1 and B ← R2 with shift = 01, then en_C and en_status with alu_op = 00 -> datapath_out = 16'h000B, Z = 0, N = 0, V = 0.
REQ-034 Bench scenario, compare: A = 5, B = 5, en_status with alu_op = 01 -> Z = 1, N = 0, V = 0, and C unchanged.
REQ-035 Bench scenario, overflow: A = 16'h7FFF, B = 1, add with en_status -> result 16'h8000, N = 1, V = 1, Z = 0.
REQ-036 Bench scenario, move: sel_A = 1, B = 16'h8004, shift = 11, alu_op = 00 -> C = 16'hC002; then with alu_op = 11 -> C = 16'h3FFD.
REQ-037 Bench scenario, read-before-write and reset: writing R4 = 9 while loading A from R4 (old value 1) -> A = 1; a subsequent rst_n = 0 for one edge -> all registers and flags read 0.
